// File: rtl/hdc_pkg.sv
// hdc_pkg: shared states, LFSR taps/seed and tap lookup for the HDC encoder
package hdc_pkg;
    typedef enum logic [2:0] {
        IDLE, READ, WAIT_DATA, BUNDLE, WAIT_DONE, WRITE, FINISH
    } bundler_ctrl_state_e;
    localparam logic [63:0] LFSR_SEED    = 64'hACE1_0000_0000_ACE1;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;
    function automatic logic [63:0] lfsr_taps(input int width);
        return width == 64 ? LFSR_TAPS_64 : {32'd0, LFSR_TAPS_32};
    endfunction
endpackage

// File: rtl/lfsr_tie_gen.sv
// lfsr_tie_gen: maximal-length Galois LFSR (WIDTH 32 or 64) supplying bundler tie bits
module lfsr_tie_gen
    import hdc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);
    // right-shifting Galois step on request; only reset restores the seed
    always_ff @(posedge clk)
        if (rst) value <= SEED;
        else if (step) value <= (value >> 1) ^ (value[0] ? TAPS : '0);
endmodule

// File: rtl/bundler_ctrl.sv
// bundler_ctrl: sequences a LANES-wide bundler bank over a DIM-bit hypervector (LFSR ties under BUNDLER_CTRL_LFSR_TIE_EN)
module bundler_ctrl
    import hdc_pkg::*;
#(
    parameter int NUM_HVS = 6,
    parameter int DIM     = 1024,
    parameter int LANES   = 32,
    localparam int BEATS  = DIM / LANES,
    localparam int AW     = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [AW-1:0]            mem_addr,
    input  logic [NUM_HVS*LANES-1:0] mem_rd_data,
    output logic                     bnd_en,
    output logic [NUM_HVS*LANES-1:0] bnd_bits,
    output logic [LANES-1:0]         bnd_tie_1,
    output logic [LANES-1:0]         bnd_tie_2,
    input  logic                     bnd_done,
    input  logic [LANES-1:0]         bnd_out,
    output logic                     out_we,
    output logic [AW-1:0]            out_addr,
    output logic [LANES-1:0]         out_data
);
    bundler_ctrl_state_e state, state_n;
    logic [AW-1:0] beat;
    logic [LANES-1:0] tie_1_n, tie_2_n;
    logic last;
    assign last = beat == AW'(BEATS - 1);
    assign mem_addr = beat;
    assign out_addr = beat;
`ifdef BUNDLER_CTRL_LFSR_TIE_EN
    logic [2*LANES-1:0] lfsr_value;
    if (NUM_HVS % 2 == 0) begin : g_lfsr
        lfsr_tie_gen #(.WIDTH(2 * LANES)) u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .step (state == WAIT_DATA),
            .value(lfsr_value)
        );
    end else begin : g_no_lfsr
        assign lfsr_value = '0;
    end
    assign {tie_2_n, tie_1_n} = lfsr_value;
`else
    assign tie_1_n = NUM_HVS % 2 == 0 ? {LANES/2{2'b01}} : '0;
    assign tie_2_n = NUM_HVS % 2 == 0 ? ~{LANES/2{2'b01}} : '0;
`endif
    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_n;
    // next state and per-state strobes
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        bnd_en    = 1'b0;
        out_we    = 1'b0;
        case (state)
            IDLE:      state_n = start ? READ : IDLE;
            READ:      begin busy = 1'b1; mem_rd_en = 1'b1; state_n = WAIT_DATA; end
            WAIT_DATA: begin busy = 1'b1; state_n = BUNDLE; end
            BUNDLE:    begin busy = 1'b1; bnd_en = 1'b1; state_n = WAIT_DONE; end
            WAIT_DONE: begin busy = 1'b1; state_n = bnd_done ? WRITE : WAIT_DONE; end
            WRITE:     begin busy = 1'b1; out_we = 1'b1; state_n = last ? FINISH : READ; end
            FINISH:    begin done = 1'b1; state_n = IDLE; end
            default:   state_n = IDLE;
        endcase
    end
    // beat counter, slice/tie capture and bundled-result capture
    always_ff @(posedge clk)
        if (rst) begin
            beat      <= '0;
            bnd_bits  <= '0;
            bnd_tie_1 <= '0;
            bnd_tie_2 <= '0;
            out_data  <= '0;
        end else begin
            if (state == WRITE && !last) beat <= beat + 1'b1;
            if (state == FINISH) beat <= '0;
            if (state == WAIT_DATA) begin
                bnd_bits  <= mem_rd_data;
                bnd_tie_1 <= tie_1_n;
                bnd_tie_2 <= tie_2_n;
            end
            if (state == WAIT_DONE && bnd_done) out_data <= bnd_out;
        end
endmodule
